load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// CPU-side request/response channel plus the data-memory port of the load/store unit.
// The unit itself connects through the slave modport; whoever plays CPU and memory
// (in practice a testbench or the surrounding core) connects through master.
interface load_store_unit_if;
  // CPU request
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  // CPU response
  logic        respValid;
  logic [31:0] respData;
  logic        respError;
  // Data memory port (word addressed, combinational read)
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] readData;

  modport slave (
    input  reqValid, reqWrite, reqSize, reqUnsigned, reqAddr, reqWData, readData,
    output reqReady, respValid, respData, respError, address, writeData, memWrite, memRead
  );

  modport master (
    output reqValid, reqWrite, reqSize, reqUnsigned, reqAddr, reqWData, readData,
    input  reqReady, respValid, respData, respError, address, writeData, memWrite, memRead
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU accesses into word-wide memory cycles.
// Sub-word stores are done as read-modify-write; misaligned or illegal accesses are
// answered with an error response and never touch memory. All outputs are registered;
// the memory strobes and reqReady are additionally gated by rst_n so that nothing is
// written or accepted while reset is held.
module load_store_unit (
  input logic             clk,
  input logic             rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;

  // Request fields kept after acceptance (only the parts later states need)
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        uns_q, uns_d;

  // Registered outputs
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;

  logic        accept_s;
  logic        req_err_s;
  logic        req_needs_read_s;

  // True when the size/alignment combination cannot be performed
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Select the addressed lane of a memory word and sign/zero extend it
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{~uns & b[7]}}, b};
      SZ_HALF: res = {{16{~uns & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane(s) of the old word with the store data
  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [15:0] wd,
                                              input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] res;
    res = old;
    case (size)
      SZ_BYTE: begin
        case (lo)
          2'b00:   res[7:0]   = wd[7:0];
          2'b01:   res[15:8]  = wd[7:0];
          2'b10:   res[23:16] = wd[7:0];
          default: res[31:24] = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lo[1]) begin
          res[31:16] = wd;
        end else begin
          res[15:0] = wd;
        end
      end
      default: res = old;
    endcase
    return res;
  endfunction

  assign accept_s         = (state_q == ST_IDLE) && bus.reqValid;
  assign req_err_s        = misaligned(bus.reqSize, bus.reqAddr[1:0]);
  assign req_needs_read_s = !bus.reqWrite || (bus.reqSize != SZ_WORD);

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_lo_q    <= 2'b00;
      wdata_q      <= 16'h0000;
      size_q       <= 2'b00;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= 32'h0000_0000;
      write_data_q <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0000_0000;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      write_q      <= write_d;
      uns_q        <= uns_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Next-state: errors skip memory, loads and sub-word stores read first
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.reqValid) begin
          if (req_err_s) begin
            state_d = ST_RESP;
          end else if (req_needs_read_s) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (write_q) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath: compute the values the registered outputs take in the next state
  always_comb begin
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    write_d      = write_q;
    uns_d        = uns_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    address_d    = address_q;
    write_data_d = write_data_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_lo_d = bus.reqAddr[1:0];
          wdata_d   = bus.reqWData[15:0];
          size_d    = bus.reqSize;
          write_d   = bus.reqWrite;
          uns_d     = bus.reqUnsigned;
          address_d = {2'b00, bus.reqAddr[31:2]};
          if (req_err_s) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_data_d  = 32'h0000_0000;
          end else if (req_needs_read_s) begin
            mem_read_d = 1'b1;
          end else begin
            mem_write_d  = 1'b1;
            write_data_d = bus.reqWData;
          end
        end else begin
          address_d = address_q;
        end
      end
      ST_READ: begin
        if (write_q) begin
          mem_write_d  = 1'b1;
          write_data_d = merge_lanes(bus.readData, wdata_q, size_q, addr_lo_q);
        end else begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_data_d  = load_extend(bus.readData, size_q, addr_lo_q, uns_q);
        end
      end
      ST_WRITE: begin
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_data_d  = 32'h0000_0000;
      end
      ST_RESP: begin
        resp_valid_d = 1'b0;
      end
      default: begin
        resp_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.reqReady  = (state_q == ST_IDLE) && rst_n;
  assign bus.memRead   = mem_read_q && rst_n;
  assign bus.memWrite  = mem_write_q && rst_n;
  assign bus.address   = address_q;
  assign bus.writeData = write_data_q;
  assign bus.respValid = resp_valid_q;
  assign bus.respData  = resp_data_q;
  assign bus.respError = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word memory driven by the unit, and a byte-array
// reference model of the same memory that predicts every response.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory seen by the unit: 16 words, combinational read, write on the edge
  logic [31:0] mem_words [0:15];
  assign bus.readData = mem_words[bus.address[3:0]];
  always @(posedge clk) begin
    if (bus.memWrite) mem_words[bus.address[3:0]] <= bus.writeData;
  end

  // Reference model: the same 64 bytes, little-endian
  logic [7:0]  ref_bytes [0:63];
  logic [31:0] last_resp;

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic scramble_fields();
    bus.reqWrite    = 1'($urandom);
    bus.reqSize     = 2'($urandom);
    bus.reqUnsigned = 1'($urandom);
    bus.reqAddr     = 32'($urandom);
    bus.reqWData    = 32'($urandom);
  endtask

  // One complete access: predict, drive, observe every cycle until the response
  task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold,
                        output logic [31:0] data_out);
    bit          err;
    int          nb;
    int          exp_lat, exp_rd, exp_wr;
    logic [63:0] val;
    logic [31:0] exp_data;
    int          rd_cnt, wr_cnt, lat;
    bit          both_seen, addr_bad, ready_bad, got;

    err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    nb  = 1 << sz;
    exp_data = 32'h0;
    if (err) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!wr) begin
      val = 64'd0;
      for (int i = 0; i < nb; i++) val = val | (64'(ref_bytes[a + i]) << (8 * i));
      if (!uns && val[8 * nb - 1]) val = val | (~64'd0 << (8 * nb));
      exp_data = val[31:0];
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
    end else begin
      for (int i = 0; i < nb; i++) ref_bytes[a + i] = 8'(wd >> (8 * i));
      exp_lat = (sz == 2'd2) ? 2 : 3;
      exp_rd  = (sz == 2'd2) ? 0 : 1;
      exp_wr  = 1;
    end

    @(negedge clk);
    check("idle_ready", 32'(bus.reqReady), 32'd1);
    check("resp_hold", bus.respData, last_resp);
    bus.reqValid    = 1'b1;
    bus.reqWrite    = wr;
    bus.reqSize     = sz;
    bus.reqUnsigned = uns;
    bus.reqAddr     = a;
    bus.reqWData    = wd;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.reqValid = 1'b0;
    rd_cnt = 0; wr_cnt = 0; lat = 0;
    both_seen = 1'b0; addr_bad = 1'b0; ready_bad = 1'b0; got = 1'b0;
    for (int c = 1; c <= 6 && !got; c++) begin
      if (bus.memRead && bus.memWrite) both_seen = 1'b1;
      if (bus.memRead) begin
        rd_cnt++;
        if (bus.address !== (a >> 2)) addr_bad = 1'b1;
      end
      if (bus.memWrite) begin
        wr_cnt++;
        if (bus.address !== (a >> 2)) addr_bad = 1'b1;
      end
      if (bus.reqReady) ready_bad = 1'b1;
      if (bus.respValid) begin
        got = 1'b1;
        lat = c;
      end
      scramble_fields();
      if (!got) @(negedge clk);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_error", 32'(bus.respError), 32'(err));
    check("resp_data", bus.respData, exp_data);
    check("mem_read_cycles", 32'(rd_cnt), 32'(exp_rd));
    check("mem_write_cycles", 32'(wr_cnt), 32'(exp_wr));
    check("rd_wr_exclusive", 32'(both_seen), 32'd0);
    check("mem_address", 32'(addr_bad), 32'd0);
    check("busy_not_ready", 32'(ready_bad), 32'd0);
    check("mem_word", mem_words[(a >> 2) & 32'd15], ref_word(int'((a >> 2) & 32'd15)));
    last_resp = bus.respData;
    data_out  = bus.respData;
  endtask

  logic [31:0] d;
  logic [31:0] ra;
  logic [1:0]  rs;

  initial begin
    rst_n           = 1'b0;
    bus.reqValid    = 1'b0;
    bus.reqWrite    = 1'b0;
    bus.reqSize     = 2'b00;
    bus.reqUnsigned = 1'b0;
    bus.reqAddr     = 32'h0;
    bus.reqWData    = 32'h0;
    last_resp       = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.reqReady), 32'd0);
    check("rst_resp_valid", 32'(bus.respValid), 32'd0);
    check("rst_resp_data", bus.respData, 32'h0);
    check("rst_resp_error", 32'(bus.respError), 32'd0);
    check("rst_mem_strobes", {30'd0, bus.memRead, bus.memWrite}, 32'd0);
    check("rst_address", bus.address, 32'h0);
    check("rst_write_data", bus.writeData, 32'h0);
    rst_n = 1'b1;

    // Fill memory through the unit with random words
    for (int w = 0; w < 16; w++) access(1'b1, 2'd2, 1'b0, 32'(4 * w), 32'($urandom), 1'b0, d);

    // Word store then word load
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, d);
    check("store_word_mem", mem_words[4], 32'hDEADBEEF);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, d);
    check("load_word", d, 32'hDEADBEEF);

    // Byte read-modify-write and signed/unsigned byte loads
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, d);
    access(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AA, 1'b0, d);
    check("store_byte_mem", mem_words[4], 32'hAA223344);
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, d);
    check("load_byte_signed", d, 32'hFFFFFFAA);
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, d);
    check("load_byte_unsigned", d, 32'h000000AA);

    // Half read-modify-write and signed half load
    access(1'b1, 2'd2, 1'b0, 32'h20, 32'h00000000, 1'b0, d);
    access(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 1'b0, d);
    check("store_half_mem", mem_words[8], 32'h80010000);
    access(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b0, d);
    check("load_half_signed", d, 32'hFFFF8001);

    // Error cases
    access(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1'b0, d);
    access(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, 1'b0, d);
    access(1'b1, 2'd3, 1'b0, 32'h08, 32'h12345678, 1'b0, d);

    // Reset during the WRITE cycle of a byte store
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.reqSize = 2'd0;
    bus.reqUnsigned = 1'b0; bus.reqAddr = 32'h31; bus.reqWData = 32'h0000005A;
    @(posedge clk);
    @(negedge clk);
    bus.reqValid = 1'b0;
    check("rmw_read_phase", 32'(bus.memRead), 32'd1);
    @(negedge clk);
    check("rmw_write_phase", 32'(bus.memWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_blocks_write", 32'(bus.memWrite), 32'd0);
    @(negedge clk);
    check("rst_abort_write", 32'(bus.memWrite), 32'd0);
    check("rst_abort_resp", 32'(bus.respValid), 32'd0);
    check("rst_abort_ready", 32'(bus.reqReady), 32'd0);
    check("rst_abort_wdata", bus.writeData, 32'h0);
    check("rst_abort_mem", mem_words[12], ref_word(12));
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", 32'(bus.reqReady), 32'd1);
    @(negedge clk);
    check("rst_no_late_resp", 32'(bus.respValid), 32'd0);
    last_resp = 32'h0;

    // reqValid held high with alternating loads and stores
    for (int k = 0; k < 20; k++) begin
      ra = 32'($urandom_range(0, 15) * 4);
      rs = 2'($urandom_range(0, 2));
      if (rs == 2'd0) ra = ra + 32'($urandom_range(0, 3));
      if (rs == 2'd1) ra = ra + 32'($urandom_range(0, 1) * 2);
      access(k[0], rs, 1'($urandom), ra, 32'($urandom), 1'b1, d);
    end
    bus.reqValid = 1'b0;

    // Random mix, mostly aligned, some misaligned or illegal
    for (int k = 0; k < 150; k++) begin
      rs = 2'($urandom);
      ra = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'd1) ra = ra & 32'h3E;
        if (rs == 2'd2) ra = ra & 32'h3C;
      end
      access(1'($urandom), rs, 1'($urandom), ra, 32'($urandom), 1'($urandom), d);
      bus.reqValid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
